text_buffer: RTL and testbench
==============================

# text_buffer

Character-cell text frame buffer that sits directly upstream of the `font` glyph ROM. A byte-stream writer with a cursor and control-code handling sits on one side. On the other side, a registered read port turns the VGA pixel position into the 8-bit character code that `font` expands into pixels. Screen clear is done by an internal state machine after reset and on form feed. Optional scrolling is compiled in by macro.

## Interface
Parameters:
- `COLS`, default 80: text columns, 8 px each; 80 fills 640 px.
- `ROWS`, default 60: text rows, 8 px each; 60 fills 480 px.

Ports:
- `px_clk` input 1: pixel clock; the only clock. All logic is on its rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `pos_x` input 10: current pixel X, in the same coordinates as the `vga_sync` `x_px` output.
- `pos_y` input 10: current pixel Y.
- `character` output 8: character code for (`pos_x`, `pos_y`). Feeds `font.character`.
- `in_data` input 8: byte to write.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the block can accept a byte this cycle.
- `cursor_col` output 7: current cursor column, 0..COLS-1.
- `cursor_row` output 6: current cursor row on screen, 0..ROWS-1.
- `busy` output 1: a clear sequence is in progress.

## Operation
- Storage is a COLS×ROWS byte array, one write port and one registered read port, both on `px_clk`. It is not reset; its contents are defined only by the clear sequence.
- Read path:
  - cell column `c = pos_x[9:3]`, cell row `r = pos_y[9:3]`.
  - If `c ≥ COLS` or `r ≥ ROWS`, `character` = 0x20.
  - Otherwise, physical row `pr = (r + top) mod ROWS`, address = `pr*COLS + c`.
- Write path: a byte is accepted on a cycle where `in_valid && in_ready`. Handling by code:
  - 0x20–0x7E: write the byte at the cursor, then advance: `col+1`. At `col == COLS-1`: `col = 0` and do a row advance.
  - 0x0A (LF): `col = 0`, then row advance.
  - 0x0D (CR): `col = 0`.
  - 0x08 (BS): `col = col-1` if `col > 0`, else no change. No write.
  - 0x0C (FF): enter CLEAR, cursor = (0,0), `top = 0`.
  - All other codes are consumed and ignored.
- Row advance:
  - If `row < ROWS-1`: `row+1`.
  - If `row == ROWS-1`: behaviour depends on `TEXT_BUFFER_SCROLL_EN` (see Configuration).
- State machine:
  - CLEAR: writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle, then goes to IDLE. `in_ready = 0`, `busy = 1`.
  - IDLE: `in_ready = 1`, `busy = 0`.
  - LINECLR (scroll build only): writes 0x20 to the COLS cells of physical row `(top-1) mod ROWS`, the new bottom line, then goes to IDLE. `in_ready = 0`, `busy = 0`.
- The read port stays active in every state, so the display shows the buffer while it is being cleared.

## Timing
- Reset (`rstn = 0`, asynchronous):
  - `character` = 0x00, `in_ready` = 0, `busy` = 1, cursor = (0,0), `top` = 0.
  - FSM state = CLEAR with the clear address at 0.
- After `rstn` deasserts:
  - CLEAR runs COLS*ROWS cycles (4800 at the defaults).
  - `in_ready` rises on the cycle after the final clear write.
- Read latency is 1 cycle. `character` at edge N+1 reflects `pos_x`/`pos_y` at edge N. The top level therefore feeds `pos_*` one cycle ahead of `font`.
- Write and cursor update happen on the accepting edge. A byte accepted at edge N is visible on the read port for an address presented at edge N+1 or later.
- A read and a write to the same address in the same cycle return the old data.
- FF accepted at edge N: `in_ready` = 0 from N+1, and CLEAR lasts COLS*ROWS cycles.
- LF at the last row (scroll build): `top` updates at edge N, and LINECLR lasts COLS cycles. Between those edges the bottom line shows stale text.
- `rstn` asserted mid-CLEAR or mid-LINECLR: immediate return to the reset state, and the full clear restarts.
- `in_valid` while `in_ready = 0`: not accepted. The sender holds `in_data`.

## Configuration
- `TEXT_BUFFER_SCROLL_EN` defined:
  - A row advance at `row == ROWS-1` keeps `row = ROWS-1`, sets `top = (top+1) mod ROWS`, and enters LINECLR.
  - The `top` register and the LINECLR state are present.
- `TEXT_BUFFER_SCROLL_EN` undefined:
  - A row advance at `row == ROWS-1` sets `row = 0`. Old text is overwritten in place.
  - `top` is constant 0 and the LINECLR state is absent.

## Test plan
- Reset release: `busy` stays 1 and `in_ready` stays 0 for exactly 4800 cycles. Afterwards, every in-range `pos` reads 0x20.
- Write "AB": read `pos` (0,0) gives 0x41 and (8,0) gives 0x42, each one cycle after `pos` is presented. Cursor = (2,0).
- Out-of-range read: `pos_x` = 640, or `pos_y` = 480 with ROWS reduced so row 60 exists as a cell index → `character` = 0x20.
- Column wrap: 80 × 0x58 → cursor = (0,1); cell (79,0) = 0x58.
  - Control codes: BS at col 0 leaves col 0; CR then 0x5A writes 0x5A at (0,1).
- Scroll build: fill 60 lines, each ending in LF. `top` = 1, `in_ready` is low for 80 cycles, the displayed row 59 reads 0x20, and the displayed row 0 shows the former line 1.
  - No-scroll build: the same stimulus gives cursor = (0,0), and row 0 keeps its old text.
- FF mid-screen followed by `rstn` pulsed 100 cycles into CLEAR: the full 4800-cycle clear restarts, and the cursor reads (0,0).

Source files
------------

// File: rtl/text_buffer_if.sv
// Byte-stream write handshake into the text buffer.
interface text_buffer_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/text_buffer.sv
// Character-cell frame buffer with cursor writer and registered VGA read port.
// Hardware scrolling is built in when TEXT_BUFFER_SCROLL_EN is defined.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_CLEAR   | write 0x20 to every cell, one per cycle; writer stalled
// ST_IDLE    | accept bytes from the writer
// ST_LINECLR | blank the new bottom line after a scroll; writer stalled
module text_buffer #(
   parameter int COLS = 80,
   parameter int ROWS = 60
) (
   input  logic        px_clk,
   input  logic        rstn,
   input  logic [9:0]  pos_x,
   input  logic [9:0]  pos_y,
   output logic [7:0]  character,
   text_buffer_if.slave wr,
   output logic [6:0]  cursor_col,
   output logic [5:0]  cursor_row,
   output logic        busy
);

   localparam int CELLS  = COLS * ROWS;
   localparam int ADDR_W = $clog2(CELLS);

   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CELLS - 1);
   localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
   localparam logic [6:0]        COL_LAST = 7'(COLS - 1);
   localparam logic [5:0]        ROW_LAST = 6'(ROWS - 1);
   localparam logic [7:0]        COLS_8   = 8'(COLS);
   localparam logic [7:0]        ROWS_8   = 8'(ROWS);

   localparam logic [1:0] ST_CLEAR   = 2'd0;
   localparam logic [1:0] ST_IDLE    = 2'd1;
`ifdef TEXT_BUFFER_SCROLL_EN
   localparam logic [1:0] ST_LINECLR = 2'd2;
`endif

   logic [1:0]        state, state_nxt;
   logic [ADDR_W-1:0] clr_addr, clr_nxt;
   logic [6:0]        col, col_nxt;
   logic [5:0]        row, row_nxt;
   logic [5:0]        top;

   logic              adv;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [7:0]        wdata;
   logic [ADDR_W-1:0] cur_addr;

   logic [7:0]        mem [0:CELLS-1];

   logic [6:0]        rd_col, rd_row;
   logic              rd_in;
   logic [ADDR_W-1:0] rd_addr;
   logic              unused_px;

   // Logical row r sits at physical row (r + top) mod ROWS; r < 128, t < ROWS.
   function automatic logic [5:0] wrap_row(input logic [6:0] r, input logic [5:0] t);
      logic [7:0] s;
      s = {1'b0, r} + {2'b0, t};
      if (s >= ROWS_8)
         s = s - ROWS_8;
      return 6'(s);
   endfunction

`ifdef TEXT_BUFFER_SCROLL_EN
   logic [5:0]        top_nxt;
   logic [5:0]        lc_row;
   logic [ADDR_W-1:0] lc_base;

   // After top advances, the fresh bottom line is physical row top-1.
   assign lc_row  = (top == 6'd0) ? ROW_LAST : top - 6'd1;
   assign lc_base = ADDR_W'(lc_row) * COLS_A;
`else
   assign top = 6'd0;
`endif

   assign cur_addr   = ADDR_W'(wrap_row({1'b0, row}, top)) * COLS_A + ADDR_W'(col);

   assign wr.in_ready = (state == ST_IDLE);
   assign busy        = (state == ST_CLEAR);
   assign cursor_col  = col;
   assign cursor_row  = row;

   always_comb begin
      state_nxt = state;
      clr_nxt   = clr_addr;
      col_nxt   = col;
      row_nxt   = row;
`ifdef TEXT_BUFFER_SCROLL_EN
      top_nxt   = top;
`endif
      adv       = 1'b0;
      we        = 1'b0;
      waddr     = cur_addr;
      wdata     = 8'h20;

      case (state)
         ST_CLEAR: begin
            we    = 1'b1;
            waddr = clr_addr;
            if (clr_addr == CLR_LAST) begin
               state_nxt = ST_IDLE;
               clr_nxt   = '0;
            end else begin
               clr_nxt = clr_addr + 1'b1;
            end
         end

`ifdef TEXT_BUFFER_SCROLL_EN
         ST_LINECLR: begin
            we    = 1'b1;
            waddr = lc_base + clr_addr;
            if (clr_addr == COLS_A - 1'b1) begin
               state_nxt = ST_IDLE;
               clr_nxt   = '0;
            end else begin
               clr_nxt = clr_addr + 1'b1;
            end
         end
`endif

         ST_IDLE: begin
            if (wr.in_valid) begin
               if (wr.in_data >= 8'h20 && wr.in_data <= 8'h7E) begin
                  we    = 1'b1;
                  wdata = wr.in_data;
                  if (col == COL_LAST) begin
                     col_nxt = 7'd0;
                     adv     = 1'b1;
                  end else begin
                     col_nxt = col + 7'd1;
                  end
               end else begin
                  case (wr.in_data)
                     8'h0A: begin
                        col_nxt = 7'd0;
                        adv     = 1'b1;
                     end
                     8'h0D: col_nxt = 7'd0;
                     8'h08: begin
                        if (col != 7'd0)
                           col_nxt = col - 7'd1;
                     end
                     8'h0C: begin
                        state_nxt = ST_CLEAR;
                        clr_nxt   = '0;
                        col_nxt   = 7'd0;
                        row_nxt   = 6'd0;
`ifdef TEXT_BUFFER_SCROLL_EN
                        top_nxt   = 6'd0;
`endif
                     end
                     default: ;
                  endcase
               end

               if (adv) begin
                  if (row != ROW_LAST) begin
                     row_nxt = row + 6'd1;
                  end else begin
`ifdef TEXT_BUFFER_SCROLL_EN
                     top_nxt   = (top == ROW_LAST) ? 6'd0 : top + 6'd1;
                     state_nxt = ST_LINECLR;
                     clr_nxt   = '0;
`else
                     row_nxt   = 6'd0;
`endif
                  end
               end
            end
         end

         default: begin
            state_nxt = ST_CLEAR;
            clr_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge px_clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_CLEAR;
         clr_addr <= '0;
         col      <= 7'd0;
         row      <= 6'd0;
`ifdef TEXT_BUFFER_SCROLL_EN
         top      <= 6'd0;
`endif
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_nxt;
         col      <= col_nxt;
         row      <= row_nxt;
`ifdef TEXT_BUFFER_SCROLL_EN
         top      <= top_nxt;
`endif
      end
   end

   // Storage has no reset; the clear sequence defines its contents.
   always_ff @(posedge px_clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rd_col    = pos_x[9:3];
   assign rd_row    = pos_y[9:3];
   assign rd_in     = ({1'b0, rd_col} < COLS_8) && ({1'b0, rd_row} < ROWS_8);
   assign rd_addr   = ADDR_W'(wrap_row(rd_row, top)) * COLS_A + ADDR_W'(rd_col);
   assign unused_px = ^{pos_x[2:0], pos_y[2:0]};

   // Same-cycle read and write of one cell returns the pre-write byte.
   always_ff @(posedge px_clk or negedge rstn) begin
      if (!rstn)
         character <= 8'h00;
      else if (rd_in)
         character <= mem[rd_addr];
      else
         character <= 8'h20;
   end

endmodule

// File: tb/tb_text_buffer.sv
// Randomized bench for text_buffer against a screen-level reference model.
module tb_text_buffer;
   localparam int COLS  = 80;
   localparam int ROWS  = 60;
   localparam int CELLS = COLS * ROWS;
`ifdef TEXT_BUFFER_SCROLL_EN
   localparam bit SCROLL = 1'b1;
`else
   localparam bit SCROLL = 1'b0;
`endif

   logic       px_clk = 1'b0;
   logic       rstn   = 1'b0;
   logic [9:0] pos_x  = '0;
   logic [9:0] pos_y  = '0;
   logic [7:0] character;
   logic [6:0] cursor_col;
   logic [5:0] cursor_row;
   logic       busy;

   text_buffer_if wr();

   text_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
      .px_clk     (px_clk),
      .rstn       (rstn),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .character  (character),
      .wr         (wr),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   always #5 px_clk = ~px_clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: the screen as displayed, plus the cursor.
   logic [7:0] scr [0:ROWS-1][0:COLS-1];
   int m_col;
   int m_row;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            scr[r][c] = 8'h20;
      m_col = 0;
      m_row = 0;
   endtask

   task automatic model_adv();
      if (m_row < ROWS - 1) begin
         m_row++;
      end else if (SCROLL) begin
         for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
               scr[r][c] = scr[r+1][c];
         for (int c = 0; c < COLS; c++)
            scr[ROWS-1][c] = 8'h20;
      end else begin
         m_row = 0;
      end
   endtask

   task automatic model_put(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         scr[m_row][m_col] = b;
         if (m_col == COLS - 1) begin
            m_col = 0;
            model_adv();
         end else begin
            m_col++;
         end
      end else if (b == 8'h0A) begin
         m_col = 0;
         model_adv();
      end else if (b == 8'h0D) begin
         m_col = 0;
      end else if (b == 8'h08) begin
         if (m_col > 0)
            m_col--;
      end else if (b == 8'h0C) begin
         model_clear();
      end
   endtask

   function automatic logic [7:0] rand_byte();
      int k;
      logic [7:0] v;
      k = int'($urandom_range(0, 99));
      if (k < 70)
         v = 8'($urandom_range(32, 126));
      else if (k < 78)
         v = 8'h0A;
      else if (k < 84)
         v = 8'h0D;
      else if (k < 91)
         v = 8'h08;
      else begin
         v = 8'($urandom_range(0, 255));
         if (v == 8'h0C || (v >= 8'h20 && v <= 8'h7E))
            v = 8'h7F;
      end
      return v;
   endfunction

   // All stimulus runs on the falling edge; outputs are sampled there too.
   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      while (wr.in_ready !== 1'b1 && n < 6000) begin
         @(negedge px_clk);
         n++;
      end
      if (wr.in_ready !== 1'b1) begin
         check("send_ready_timeout", 32'(wr.in_ready), 1);
         return;
      end
      wr.in_data  = b;
      wr.in_valid = 1'b1;
      @(negedge px_clk);
      wr.in_valid = 1'b0;
      model_put(b);
   endtask

   task automatic read_px(input int x, input int y, output logic [7:0] v);
      pos_x = 10'(x);
      pos_y = 10'(y);
      @(negedge px_clk);
      v = character;
   endtask

   task automatic read_cell(input int c, input int r, output logic [7:0] v);
      read_px(c * 8 + int'($urandom_range(0, 7)), r * 8 + int'($urandom_range(0, 7)), v);
   endtask

   task automatic compare_screen(input string tag);
      int errs;
      logic [7:0] v;
      errs = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            read_cell(c, r, v);
            if (v !== scr[r][c])
               errs++;
         end
      check(tag, errs, 0);
   endtask

   task automatic count_clear(output int n, output int rdy_hi);
      n = 0;
      rdy_hi = 0;
      while (busy === 1'b1 && n < 10000) begin
         if (wr.in_ready !== 1'b0)
            rdy_hi++;
         @(negedge px_clk);
         n++;
      end
   endtask

   task automatic check_cursor(input string tag);
      check({tag, "_col"}, 32'(cursor_col), m_col);
      check({tag, "_row"}, 32'(cursor_row), m_row);
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] old;
      int n;
      int rdy_hi;

      wr.in_valid = 1'b0;
      wr.in_data  = 8'h00;
      model_clear();

      repeat (3) @(negedge px_clk);
      check("rst_character", 32'(character), 8'h00);
      check("rst_ready", 32'(wr.in_ready), 0);
      check("rst_busy", 32'(busy), 1);
      check_cursor("rst_cursor");

      rstn = 1'b1;
      count_clear(n, rdy_hi);
      check("clear_cycles", n, CELLS);
      check("clear_ready_low", rdy_hi, 0);
      check("ready_after_clear", 32'(wr.in_ready), 1);
      compare_screen("screen_after_reset");

      send(8'h41);
      send(8'h42);
      read_px(16, 0, v);
      check("lat_cell_2_0", v, scr[0][2]);
      read_px(0, 0, v);
      check("cell_0_0", v, scr[0][0]);
      read_px(8 + 3, 5, v);
      check("cell_1_0", v, scr[0][1]);
      check_cursor("ab_cursor");

      send(8'h0D);
      for (int i = 0; i < COLS; i++)
         send(8'h58);
      check_cursor("wrap_cursor");
      read_px(79 * 8, 0, v);
      check("wrap_cell_79_0", v, scr[0][79]);

      send(8'h08);
      check_cursor("bs_col0_cursor");
      send(8'h0D);
      send(8'h5A);
      read_px(0, 8, v);
      check("cr_cell_0_1", v, scr[1][0]);
      check_cursor("cr_cursor");

      // Read the cell being written on the same edge: old byte expected.
      old = scr[1][1];
      pos_x       = 10'd8;
      pos_y       = 10'd8;
      wr.in_data  = 8'h51;
      wr.in_valid = 1'b1;
      @(negedge px_clk);
      wr.in_valid = 1'b0;
      v = character;
      model_put(8'h51);
      check("rw_same_old", v, old);
      read_px(8, 8, v);
      check("rw_same_new", v, scr[1][1]);

      read_px(640, 0, v);
      check("oor_x640", v, 8'h20);
      read_px(0, 480, v);
      check("oor_y480", v, 8'h20);
      read_px(1023, 1023, v);
      check("oor_max", v, 8'h20);
      read_px(639, 479, v);
      check("inr_last_cell", v, scr[59][79]);

      for (int i = 0; i < 300; i++) begin
         send(rand_byte());
         check_cursor("rand1");
      end
      compare_screen("screen_rand1");

      send(8'h0C);
      check("ff_busy", 32'(busy), 1);
      check("ff_ready", 32'(wr.in_ready), 0);
      check_cursor("ff_cursor");

      for (int l = 0; l < ROWS; l++) begin
         for (int j = 0; j <= l % 7; j++)
            send(8'(8'h41 + l % 26));
         if (l < ROWS - 1)
            send(8'h0A);
      end
      send(8'h0A);
      n = 0;
      while (wr.in_ready !== 1'b1 && n < 10000) begin
         @(negedge px_clk);
         n++;
      end
      check("scroll_ready_low", n, SCROLL ? COLS : 0);
      check_cursor("fill_cursor");
      read_cell(0, 0, v);
      check("fill_row0", v, scr[0][0]);
      read_cell(0, ROWS - 1, v);
      check("fill_row59", v, scr[ROWS-1][0]);
      compare_screen("screen_fill");

      for (int i = 0; i < 200; i++) begin
         send(rand_byte());
         check_cursor("rand2");
      end
      compare_screen("screen_rand2");

      send(8'h41);
      send(8'h0C);
      repeat (100) @(negedge px_clk);
      check("ff_mid_busy", 32'(busy), 1);
      rstn = 1'b0;
      #1;
      check("rst_mid_character", 32'(character), 8'h00);
      check("rst_mid_busy", 32'(busy), 1);
      check("rst_mid_ready", 32'(wr.in_ready), 0);
      @(negedge px_clk);
      @(negedge px_clk);
      rstn = 1'b1;
      count_clear(n, rdy_hi);
      check("reclear_cycles", n, CELLS);
      check("reclear_ready_low", rdy_hi, 0);
      model_clear();
      check_cursor("reclear_cursor");
      compare_screen("screen_reclear");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
